// File: rtl/sweep_ctrl.sv
// sweep_ctrl: drives an up/down counter through bounded triangle sweeps with dwell at each extreme
module sweep_ctrl #(
   parameter int N           = 8,
   parameter int DWELL_W     = 4,
   parameter int CYC_W       = 8,
   parameter bit CLR_ON_DONE = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               dir_init,
   input  logic [N-1:0]       start_val,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [CYC_W-1:0]   num_sweeps,
   input  logic               max_tick,
   input  logic               min_tick,
   output logic               syn_clr,
   output logic               load,
   output logic [N-1:0]       d,
   output logic               en,
   output logic               up,
   output logic               busy,
   output logic               done,
   output logic [CYC_W-1:0]   sweep_cnt
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN_UP, RUN_DN, DWELL_TOP, DWELL_BOT, DONE} state_t;
   state_t state, nxt;
   logic dir_r;
   logic [DWELL_W-1:0] dwell_r, dcnt;
   logic [CYC_W-1:0] num_r, cnt_inc;
   logic dwell_end, hit, in_dwell, to_dwell;
   assign cnt_inc   = sweep_cnt + 1'b1;
   assign dwell_end = dcnt == '0;
   assign hit       = num_r != '0 && cnt_inc == num_r;
   assign in_dwell  = state == DWELL_TOP || state == DWELL_BOT;
   assign to_dwell  = (state == RUN_UP && nxt == DWELL_TOP) || (state == RUN_DN && nxt == DWELL_BOT);
   assign busy      = state != IDLE;
   // next state and counter controls; en is gated by the tick so the counter never overshoots
   always_comb begin
      nxt = state;
      load = 1'b0;
      en = 1'b0;
      up = 1'b0;
      syn_clr = 1'b0;
      done = 1'b0;
      case (state)
         IDLE: nxt = start ? LOAD : IDLE;
         LOAD: begin
            load = 1'b1;
            nxt = stop ? DONE : dir_r ? RUN_UP : RUN_DN;
         end
         RUN_UP: begin
            up = 1'b1;
            en = ~max_tick & ~stop;
            nxt = stop ? DONE : max_tick ? DWELL_TOP : RUN_UP;
         end
         RUN_DN: begin
            en = ~min_tick & ~stop;
            nxt = stop ? DONE : min_tick ? DWELL_BOT : RUN_DN;
         end
         DWELL_TOP: begin
            up = 1'b1;
            nxt = stop ? DONE : !dwell_end ? DWELL_TOP : hit ? DONE : RUN_DN;
         end
         DWELL_BOT: nxt = stop ? DONE : !dwell_end ? DWELL_BOT : hit ? DONE : RUN_UP;
         DONE: begin
            done = 1'b1;
            syn_clr = CLR_ON_DONE;
            nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else state <= nxt;
   end
   // run configuration, dwell timer and half-sweep counter; an aborted dwell does not count
   always_ff @(posedge clk) begin
      if (!reset) begin
         d <= '0;
         dir_r <= 1'b0;
         dwell_r <= '0;
         num_r <= '0;
         dcnt <= '0;
         sweep_cnt <= '0;
      end else begin
         if (state == IDLE && start) begin
            d <= start_val;
            dir_r <= dir_init;
            dwell_r <= dwell;
            num_r <= num_sweeps;
            sweep_cnt <= '0;
         end
         if (to_dwell) dcnt <= dwell_r;
         else if (in_dwell) dcnt <= dcnt - 1'b1;
         if (in_dwell && dwell_end && !stop) sweep_cnt <= cnt_inc;
      end
   end
endmodule
